// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types and default sizes for the SNN timestep sequencer slice.
//   seq_state_t          : sequencer FSM state encoding
//   NUM_NEURONS_DEFAULT  : default number of neurons swept/read out
//   SIM_TIME_W_DEFAULT   : default width of sim_time / timestep
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int NUM_NEURONS_DEFAULT = 16;
    localparam int SIM_TIME_W_DEFAULT  = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_CLEAR  = 3'd1,
        SEQ_INPUT  = 3'd2,
        SEQ_UPDATE = 3'd3,
        SEQ_OUTPUT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/snn_index_counter.sv
// -----------------------------------------------------------------------------
// snn_index_counter
// Wrapping index counter used for both the neuron index and the timestep.
//   clk         : system clock
//   rst         : synchronous active-high reset (count -> 0)
//   clr         : synchronous clear (count -> 0), wins over en
//   en          : advance the count by one this cycle
//   terminal    : last value before wrapping back to 0
//   count       : current count
//   at_terminal : count == terminal
// The terminal value is a port so the same block serves a constant bound
// (neuron index) and a run-time bound (latched sim_time - 1).
// -----------------------------------------------------------------------------
module snn_index_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         at_terminal
);

    logic [W-1:0] r_count;

    assign at_terminal = (r_count == terminal);
    assign count       = r_count;

    // Count register: clear has priority, wrap to 0 when advancing at terminal.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= {W{1'b0}};
        end else if (en) begin
            if (at_terminal) begin
                r_count <= {W{1'b0}};
            end else begin
                r_count <= r_count + W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/snn_timestep_sequencer.sv
// -----------------------------------------------------------------------------
// snn_timestep_sequencer
// Drives an SNN inference run: clear spike counters, then per timestep one
// input-generation pulse followed by a one-neuron-per-cycle update sweep,
// then an indexed readout of all neurons.
//   clk, rst          : clock, synchronous active-high reset
//   start, sim_time   : run request (IDLE only) and number of timesteps
//   abort             : cancel run, return to IDLE with counters zeroed
//   neuron_stall      : back-pressure during the update sweep
//   out_ready         : readout consumer ready
//   done / busy       : IDLE indication and its inverse
//   spike_cnt_clr     : one-cycle clear of output spike counters
//   input_gen_en      : one-cycle pulse at the start of each timestep
//   neuron_update_en  : update neuron_idx this cycle
//   neuron_idx        : neuron being updated or read out
//   timestep          : current timestep
//   last_timestep     : timestep == latched sim_time - 1
//   out_valid         : readout data for neuron_idx is valid
// -----------------------------------------------------------------------------
module snn_timestep_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    parameter int SIM_TIME_W  = SIM_TIME_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIM_TIME_W-1:0] sim_time,
    input  logic                  abort,
    input  logic                  neuron_stall,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  busy,
    output logic                  spike_cnt_clr,
    output logic                  input_gen_en,
    output logic                  neuron_update_en,
    output logic [IDX_W-1:0]      neuron_idx,
    output logic [SIM_TIME_W-1:0] timestep,
    output logic                  last_timestep,
    output logic                  out_valid
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [SIM_TIME_W-1:0] r_sim_time_q;

    logic                  w_upd_fire;
    logic                  w_rd_fire;
    logic                  w_abort_run;
    logic                  w_idx_clr;
    logic                  w_idx_en;
    logic                  w_idx_term;
    logic                  w_ts_clr;
    logic                  w_ts_en;
    logic                  w_ts_term;
    logic [SIM_TIME_W-1:0] w_ts_terminal;
    logic                  w_accept;

    assign w_accept      = (r_state == SEQ_IDLE) && start && !abort;
    assign w_upd_fire    = (r_state == SEQ_UPDATE) && !neuron_stall;
    assign w_rd_fire     = (r_state == SEQ_OUTPUT) && out_ready;
    assign w_abort_run   = abort && (r_state != SEQ_IDLE);
    // With sim_time_q == 0 this wraps to all-ones; UPDATE is never entered then.
    assign w_ts_terminal = r_sim_time_q - SIM_TIME_W'(1);

    // Neuron index: cleared entering a run or on abort, advanced by updates
    // and by readout transfers; the wrap at the last neuron is the sweep end.
    assign w_idx_clr = w_abort_run || (r_state == SEQ_CLEAR);
    assign w_idx_en  = w_upd_fire || w_rd_fire;

    // Timestep: advances at the end of every sweep except the last, and is
    // returned to 0 once the final readout transfer completes.
    assign w_ts_clr = w_abort_run || (r_state == SEQ_CLEAR) || (w_rd_fire && w_idx_term);
    assign w_ts_en  = w_upd_fire && w_idx_term && !w_ts_term;

    snn_index_counter #(
        .W (IDX_W)
    ) u_idx_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (w_idx_clr),
        .en          (w_idx_en),
        .terminal    (IDX_LAST),
        .count       (neuron_idx),
        .at_terminal (w_idx_term)
    );

    snn_index_counter #(
        .W (SIM_TIME_W)
    ) u_ts_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (w_ts_clr),
        .en          (w_ts_en),
        .terminal    (w_ts_terminal),
        .count       (timestep),
        .at_terminal (w_ts_term)
    );

    // Next-state decode; abort out of any active state overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEQ_CLEAR;
                end else begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            SEQ_CLEAR: begin
                if (r_sim_time_q == {SIM_TIME_W{1'b0}}) begin
                    w_state_nxt = SEQ_OUTPUT;
                end else begin
                    w_state_nxt = SEQ_INPUT;
                end
            end
            SEQ_INPUT: begin
                w_state_nxt = SEQ_UPDATE;
            end
            SEQ_UPDATE: begin
                if (w_upd_fire && w_idx_term) begin
                    if (w_ts_term) begin
                        w_state_nxt = SEQ_OUTPUT;
                    end else begin
                        w_state_nxt = SEQ_INPUT;
                    end
                end else begin
                    w_state_nxt = SEQ_UPDATE;
                end
            end
            SEQ_OUTPUT: begin
                if (w_rd_fire && w_idx_term) begin
                    w_state_nxt = SEQ_IDLE;
                end else begin
                    w_state_nxt = SEQ_OUTPUT;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
        if (w_abort_run) begin
            w_state_nxt = SEQ_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run length is captured only when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sim_time_q <= {SIM_TIME_W{1'b0}};
        end else if (w_accept) begin
            r_sim_time_q <= sim_time;
        end else begin
            r_sim_time_q <= r_sim_time_q;
        end
    end

    assign done             = (r_state == SEQ_IDLE);
    assign busy             = !done;
    assign spike_cnt_clr    = (r_state == SEQ_CLEAR);
    assign input_gen_en     = (r_state == SEQ_INPUT);
    assign neuron_update_en = w_upd_fire;
    assign out_valid        = (r_state == SEQ_OUTPUT);
    assign last_timestep    = w_ts_term;

endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// Scoreboard bench: each launched run pushes the event stream the sequencer
// must produce (clear, per-timestep input pulse, updates, readouts, busy
// length); a negedge monitor pops and compares as the DUT emits events.
module tb_snn_timestep_sequencer;

    localparam int N  = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] sim_time;
    logic          abort;
    logic          neuron_stall;
    logic          out_ready;
    logic          done;
    logic          busy;
    logic          spike_cnt_clr;
    logic          input_gen_en;
    logic          neuron_update_en;
    logic [1:0]    neuron_idx;
    logic [TW-1:0] timestep;
    logic          last_timestep;
    logic          out_valid;

    snn_timestep_sequencer #(
        .NUM_NEURONS (N),
        .SIM_TIME_W  (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .sim_time         (sim_time),
        .abort            (abort),
        .neuron_stall     (neuron_stall),
        .out_ready        (out_ready),
        .done             (done),
        .busy             (busy),
        .spike_cnt_clr    (spike_cnt_clr),
        .input_gen_en     (input_gen_en),
        .neuron_update_en (neuron_update_en),
        .neuron_idx       (neuron_idx),
        .timestep         (timestep),
        .last_timestep    (last_timestep),
        .out_valid        (out_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected event streams.
    int exp_upd[$];   // timestep*256 + idx for each neuron update
    int exp_inp[$];   // timestep for each input pulse
    int exp_rd[$];    // idx for each readout transfer
    int exp_len[$];   // busy cycles per run, -1 = not checked
    int exp_clr = 0;  // pending spike counter clears
    int exp_last[$];  // last_timestep value expected with each update

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   busy_cnt  = 0;
    logic prev_busy = 1'b0;
    logic prev_hold = 1'b0;
    int   prev_idx  = 0;
    int   e_len;

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            prev_hold = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (spike_cnt_clr) begin
                chk("clr_pending", int'(exp_clr > 0), 1);
                if (exp_clr > 0) exp_clr--;
            end
            if (input_gen_en) begin
                chk("inp_pending", int'(exp_inp.size() > 0), 1);
                if (exp_inp.size() > 0) chk("inp_timestep", int'(timestep), exp_inp.pop_front());
            end
            if (neuron_update_en) begin
                chk("upd_no_stall", int'(neuron_stall), 0);
                chk("upd_pending", int'(exp_upd.size() > 0), 1);
                if (exp_upd.size() > 0) begin
                    chk("upd_ts_idx", int'(timestep) * 256 + int'(neuron_idx), exp_upd.pop_front());
                    chk("upd_last_ts", int'(last_timestep), exp_last.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                chk("rd_pending", int'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("rd_idx", int'(neuron_idx), exp_rd.pop_front());
            end
            chk("busy_not_done", int'(busy), int'(!done));
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_idx", int'(neuron_idx), prev_idx);
            end
            prev_hold = out_valid && !out_ready;
            prev_idx  = int'(neuron_idx);
            if (busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                chk("len_pending", int'(exp_len.size() > 0), 1);
                if (exp_len.size() > 0) begin
                    e_len = exp_len.pop_front();
                    if (e_len >= 0) chk("busy_len", busy_cnt, e_len);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Reference: clear, then S timesteps of (input pulse, N updates), then N
    // readouts; with no back-pressure busy = 1 + S*(N+1) + N, plus each
    // back-pressured cycle.
    task automatic launch(input int s, input int extra);
        exp_clr++;
        for (int t = 0; t < s; t++) begin
            exp_inp.push_back(t);
            for (int i = 0; i < N; i++) begin
                exp_upd.push_back(t * 256 + i);
                exp_last.push_back(int'(t == s - 1));
            end
        end
        for (int i = 0; i < N; i++) exp_rd.push_back(i);
        exp_len.push_back(extra < 0 ? -1 : 1 + s * (N + 1) + N + extra);
        @(posedge clk); #1;
        start    = 1'b1;
        sim_time = TW'(s);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic flush_events();
        exp_upd.delete();
        exp_inp.delete();
        exp_rd.delete();
        exp_last.delete();
        exp_clr = 0;
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        chk({name, "_upd_left"}, exp_upd.size(), 0);
        chk({name, "_inp_left"}, exp_inp.size(), 0);
        chk({name, "_rd_left"}, exp_rd.size(), 0);
        chk({name, "_len_left"}, exp_len.size(), 0);
        chk({name, "_clr_left"}, exp_clr, 0);
    endtask

    // Wait for done; in random mode also toggles stall/ready and fires
    // start while busy (which must be ignored).
    task automatic wait_done(input bit rnd, input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 3000) begin
                chk({name, "_timeout"}, n, 0);
                break;
            end
            if (rnd) begin
                @(posedge clk); #1;
                neuron_stall = ($urandom_range(0, 3) == 0);
                out_ready    = ($urandom_range(0, 2) != 0);
                start        = 1'($urandom_range(0, 1));
                sim_time     = TW'($urandom_range(0, 7));
            end
        end
        start        = 1'b0;
        neuron_stall = 1'b0;
        out_ready    = 1'b1;
        check_drained(name);
    endtask

    // kind 0: update at (a,b); kind 1: readout transfer at idx a
    task automatic wait_event(input int kind, input int a, input int b, input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (kind == 0 && neuron_update_en && int'(timestep) == a && int'(neuron_idx) == b) break;
            if (kind == 1 && out_valid && out_ready && int'(neuron_idx) == a) break;
            n++;
            if (n > 500) begin
                chk({name, "_wait_timeout"}, n, 0);
                break;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        neuron_stall = 1'b0;
        out_ready    = 1'b1;
        sim_time     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_done", int'(done), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({spike_cnt_clr, input_gen_en, neuron_update_en, out_valid}), 0);
        chk("rst_idx", int'(neuron_idx), 0);
        chk("rst_ts", int'(timestep), 0);

        // nominal S=3: busy 20
        launch(3, 0);
        wait_done(1'b0, "nominal");

        // S=0: clear then readout only, busy 5
        launch(0, 0);
        wait_done(1'b0, "simtime0");

        // stall 2 cycles at timestep 1, idx 2: busy 22
        launch(3, 2);
        wait_event(0, 1, 1, "stall");
        @(posedge clk); #1 neuron_stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_idx", int'(neuron_idx), 2);
            chk("stall_upd_en", int'(neuron_update_en), 0);
            @(posedge clk);
        end
        #1 neuron_stall = 1'b0;
        wait_done(1'b0, "stall");

        // out_ready low 3 cycles at readout idx 1: busy 23
        launch(3, 3);
        wait_event(1, 0, 0, "ready");
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ready_valid", int'(out_valid), 1);
            chk("ready_idx", int'(neuron_idx), 1);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        wait_done(1'b0, "ready");

        // abort during UPDATE at timestep 1
        launch(3, -1);
        wait_event(0, 1, 0, "abort");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        flush_events();
        @(negedge clk);
        chk("abort_done", int'(done), 1);
        chk("abort_ts", int'(timestep), 0);
        chk("abort_idx", int'(neuron_idx), 0);
        launch(2, 0);
        wait_done(1'b0, "after_abort");

        // start && abort in IDLE: no run
        @(posedge clk); #1;
        start    = 1'b1;
        abort    = 1'b1;
        sim_time = TW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_done", int'(done), 1);
        chk("start_abort_clr", int'(spike_cnt_clr), 0);

        // rst pulse mid-OUTPUT
        launch(1, -1);
        wait_event(1, 1, 0, "rst_mid");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        flush_events();
        exp_len.delete();
        @(negedge clk);
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_done", int'(done), 1);
        chk("rst_mid_idx", int'(neuron_idx), 0);

        // randomized runs with back-pressure and start-while-busy
        for (int r = 0; r < 8; r++) begin
            launch(int'($urandom_range(0, 4)), -1);
            wait_done(1'b1, "random");
        end

        // one more clean run after the random traffic
        launch(1, 0);
        wait_done(1'b0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_timestep_sequencer.md
Name: snn_timestep_sequencer

Overview:
- Sequences the SNN core through a full inference run: per-neuron spike-count clear, then for each simulation timestep an input-spike generation pulse and a one-neuron-per-cycle update sweep, then an indexed readout of the results.
- Sits between the top-level core controller (start/done) and the network datapath: input spike generator, neuron array, and output spike counters.
- Owns the timestep and neuron-index counters so the datapath carries no sequencing logic.

Parameters:
- NUM_NEURONS, 16, number of output neurons swept per timestep and read out; must be >= 1.
- IDX_W, $clog2(NUM_NEURONS) (minimum 1), width of neuron_idx.
- SIM_TIME_W, 16, width of the sim_time and timestep fields.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled run request; honoured only in IDLE.
- sim_time  in  SIM_TIME_W  number of timesteps; latched when start is accepted.
- abort  in  1  cancel the run; return to IDLE.
- neuron_stall  in  1  datapath back-pressure during the update sweep.
- out_ready  in  1  readout consumer ready.
- done  out  1  high in IDLE.
- busy  out  1  inverse of done.
- spike_cnt_clr  out  1  one-cycle clear of all output spike counters.
- input_gen_en  out  1  one-cycle pulse at the start of each timestep.
- neuron_update_en  out  1  update the neuron selected by neuron_idx this cycle.
- neuron_idx  out  IDX_W  neuron being updated, or being read out.
- timestep  out  SIM_TIME_W  current timestep, 0..sim_time-1.
- last_timestep  out  1  high while timestep == latched sim_time-1.
- out_valid  out  1  readout data for neuron_idx is valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, neuron_idx=0, timestep=0, sim_time_q=0. Resulting outputs: done=1, busy=0, all pulse/enable outputs and out_valid 0.
- rst asserted mid-run: IDLE on the next edge, same values as above. No readout is emitted.
- Output decoding: all outputs are Moore decodes of state and counters. Exception: neuron_update_en = (state==UPDATE) && !neuron_stall.
- IDLE: done=1. On start && !abort:
  - latch sim_time into sim_time_q;
  - go to CLEAR.
- CLEAR (1 cycle): spike_cnt_clr=1; timestep<=0; neuron_idx<=0. Next state is INPUT, or OUTPUT if sim_time_q==0.
- INPUT (1 cycle): input_gen_en=1; next state UPDATE.
- UPDATE:
  - neuron_idx advances only on cycles where neuron_update_en=1.
  - neuron_stall holds neuron_idx and the state.
  - On an update at neuron_idx==NUM_NEURONS-1, neuron_idx wraps to 0.
  - At that wrap: if last_timestep, go to OUTPUT; otherwise timestep+=1 and go to INPUT.
- OUTPUT:
  - out_valid=1.
  - On out_valid && out_ready: neuron_idx+=1.
  - The transfer at index NUM_NEURONS-1 goes to IDLE with neuron_idx<=0.
  - out_ready low holds neuron_idx and out_valid.
- abort: from any non-IDLE state, IDLE on the next edge with counters zeroed. In IDLE, abort takes priority over start and the run is not started.
- Ignored inputs: start outside IDLE; neuron_stall outside UPDATE; out_ready outside OUTPUT.
- Timing with no stalls and out_ready held high: busy lasts exactly 1 + S*(NUM_NEURONS+1) + NUM_NEURONS cycles, where S = sim_time_q.
- Counter widths: timestep never exceeds sim_time_q-1, so there is no overflow. The maximum sim_time is 2^SIM_TIME_W-1.
- NUM_NEURONS==1: UPDATE lasts one cycle per timestep (unless stalled); OUTPUT is a single transfer.

Decomposition:
- Package snn_pkg:
  - seq_state_t enum {IDLE, CLEAR, INPUT, UPDATE, OUTPUT};
  - shared localparam defaults for NUM_NEURONS and SIM_TIME_W.
- Sub-module snn_index_counter, used twice (neuron_idx and timestep):
  - parameterised width and terminal value;
  - inputs clr and en;
  - outputs count and at_terminal.
  - Count wraps to 0 on en at the terminal value.

Test Plan:
- Nominal run, NUM_NEURONS=4, sim_time=3, out_ready=1, no stall: input_gen_en pulses 3 times; neuron_update_en high 12 cycles with idx 0,1,2,3 repeated; 4 out_valid transfers; busy high exactly 20 cycles; done returns to 1.
- sim_time=0: CLEAR then OUTPUT directly; no input_gen_en or neuron_update_en; busy high exactly 5 cycles (1 + 4 readout).
- neuron_stall high 2 cycles at timestep 1, idx 2: neuron_idx holds at 2, neuron_update_en low; total busy becomes 22 cycles.
- out_ready low 3 cycles at readout idx 1: out_valid stays high, neuron_idx stays 1; busy extends by 3 cycles.
- abort during UPDATE at timestep 1: next cycle state IDLE, done=1, timestep=0, neuron_idx=0. A start in the following cycle begins a fresh run with spike_cnt_clr.
- Boundary controls:
  - start && abort in IDLE: the run does not start.
  - rst pulse mid-OUTPUT: IDLE next edge, out_valid=0.
  - start while busy: no effect on the sequence.
